// File: rtl/matrix_pkg.sv
// Shared sizing, FSM state type and tile helpers for the matrix assembler.
// Element width, tile size and matrix size are fixed here for the whole slice.
package matrix_pkg;

    localparam int MATRIX_SIZE = 128;
    localparam int BLOCK_SIZE  = 64;
    localparam int DATA_WIDTH  = 16;
    localparam int NUM_BLK     = MATRIX_SIZE / BLOCK_SIZE;
    localparam int NUM_TILES   = NUM_BLK * NUM_BLK;
    localparam int IDX_W       = 2;
    localparam int RCNT_W      = $clog2(BLOCK_SIZE);
    localparam int POS_W       = $clog2(MATRIX_SIZE);
    localparam int ROW_BITS    = BLOCK_SIZE * DATA_WIDTH;
    localparam int FLAT_W      = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } asm_state_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] r,
                                          input logic [IDX_W-1:0] c);
        return (int'(r) < NUM_BLK) && (int'(c) < NUM_BLK);
    endfunction

    // One-hot bitmap position of tile (r,c); all zeros for an out-of-range tile.
    function automatic logic [NUM_TILES-1:0] tile_mask(input logic [IDX_W-1:0] r,
                                                       input logic [IDX_W-1:0] c);
        logic [NUM_TILES-1:0] mask;
        mask = '0;
        if (idx_in_range(r, c)) begin
            mask = NUM_TILES'(1) << (int'(r) * NUM_BLK + int'(c));
        end
        return mask;
    endfunction

endpackage

// File: rtl/matrix_assembler_if.sv
// Tile-row input stream and assembled-matrix output of the matrix assembler.
// The master modport is the producer/consumer side, the slave modport the assembler.
interface matrix_assembler_if;
    import matrix_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IDX_W-1:0]    row_block_idx;
    logic [IDX_W-1:0]    col_block_idx;
    logic [ROW_BITS-1:0] block_row_flat;
    logic                out_valid;
    logic                out_ready;
    logic [FLAT_W-1:0]   large_matrix_flat;
    logic                dup_err;
    logic                idx_err;

    modport master (
        output in_valid, row_block_idx, col_block_idx, block_row_flat, out_ready,
        input  in_ready, out_valid, large_matrix_flat, dup_err, idx_err
    );

    modport slave (
        input  in_valid, row_block_idx, col_block_idx, block_row_flat, out_ready,
        output in_ready, out_valid, large_matrix_flat, dup_err, idx_err
    );

endinterface

// File: rtl/assembler_tile_tracker.sv
// Tile bookkeeping for the assembler: row counter, latched tile index, written-tile
// bitmap, duplicate/range checks and the IDLE/FILL/DONE control FSM.
module assembler_tile_tracker
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] row_block_idx,
    input  logic [IDX_W-1:0] col_block_idx,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             dup_err,
    output logic             idx_err,
    output logic             wr_en,
    output logic [POS_W-1:0] wr_row,
    output logic [POS_W-1:0] wr_col_base
);

    asm_state_t           state_q, state_d;
    logic                 ready_q;
    logic [RCNT_W-1:0]    rcnt_q;
    logic [IDX_W-1:0]     tile_r_q, tile_c_q;
    logic                 discard_q;
    logic [NUM_TILES-1:0] bitmap_q, bitmap_d;
    logic                 dup_err_q, idx_err_q;

    logic                 accept, first_beat, last_beat, frame_taken;
    logic [IDX_W-1:0]     cur_r, cur_c;
    logic                 cur_bad;

    // ready_q keeps in_ready low through reset without any path from in_valid.
    assign in_ready    = ready_q && (state_q != DONE);
    assign out_valid   = (state_q == DONE);
    assign dup_err     = dup_err_q;
    assign idx_err     = idx_err_q;

    assign accept      = in_valid && in_ready;
    assign first_beat  = accept && (state_q == IDLE);
    assign last_beat   = accept && (state_q == FILL) && (rcnt_q == RCNT_W'(BLOCK_SIZE - 1));
    assign frame_taken = out_valid && out_ready;

    // The first beat of a tile uses the live indices; later beats use the latched ones.
    assign cur_r       = first_beat ? row_block_idx : tile_r_q;
    assign cur_c       = first_beat ? col_block_idx : tile_c_q;
    assign cur_bad     = first_beat ? !idx_in_range(row_block_idx, col_block_idx) : discard_q;

    assign wr_en       = accept && !cur_bad;
    assign wr_row      = POS_W'(cur_r) * POS_W'(BLOCK_SIZE) + POS_W'(rcnt_q);
    assign wr_col_base = POS_W'(cur_c) * POS_W'(BLOCK_SIZE);

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        bitmap_d = bitmap_q;
        if (last_beat && !discard_q) begin
            bitmap_d = bitmap_q | tile_mask(tile_r_q, tile_c_q);
        end
        unique case (state_q)
            IDLE: if (first_beat) state_d = FILL;
            FILL: if (last_beat) state_d = (&bitmap_d) ? DONE : IDLE;
            DONE: begin
                if (frame_taken) begin
                    state_d  = IDLE;
                    bitmap_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            rcnt_q    <= '0;
            tile_r_q  <= '0;
            tile_c_q  <= '0;
            discard_q <= 1'b0;
            bitmap_q  <= '0;
            dup_err_q <= 1'b0;
            idx_err_q <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            bitmap_q <= bitmap_d;
            if (accept) begin
                rcnt_q <= last_beat ? '0 : rcnt_q + 1'b1;
            end
            if (first_beat) begin
                tile_r_q  <= row_block_idx;
                tile_c_q  <= col_block_idx;
                discard_q <= !idx_in_range(row_block_idx, col_block_idx);
            end
            if (frame_taken) begin
                dup_err_q <= 1'b0;
                idx_err_q <= 1'b0;
            end else if (first_beat) begin
                if (!idx_in_range(row_block_idx, col_block_idx)) begin
                    idx_err_q <= 1'b1;
                end else if (|(bitmap_q & tile_mask(row_block_idx, col_block_idx))) begin
                    dup_err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_assembler.sv
// Rebuilds a MATRIX_SIZE x MATRIX_SIZE matrix from tile rows; the tracker steers each
// accepted beat to one tile-row-wide segment of the matrix storage.
module matrix_assembler
    import matrix_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    matrix_assembler_if.slave bus
);

    logic             wr_en;
    logic [POS_W-1:0] wr_row;
    logic [POS_W-1:0] wr_col_base;

    assembler_tile_tracker u_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (bus.in_valid),
        .row_block_idx (bus.row_block_idx),
        .col_block_idx (bus.col_block_idx),
        .out_ready     (bus.out_ready),
        .in_ready      (bus.in_ready),
        .out_valid     (bus.out_valid),
        .dup_err       (bus.dup_err),
        .idx_err       (bus.idx_err),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_col_base   (wr_col_base)
    );

    // Storage is split into tile-row segments so each segment has a single write decode.
    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
        for (genvar b = 0; b < NUM_BLK; b++) begin : g_seg
            logic [ROW_BITS-1:0] seg_q;
            logic                hit;

            assign hit = wr_en && (wr_row == POS_W'(r)) && (wr_col_base == POS_W'(b * BLOCK_SIZE));

            // NOTE: the matrix storage is reset because the assembled output must read zero after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    seg_q <= '0;
                end else if (hit) begin
                    seg_q <= bus.block_row_flat;
                end
            end

            assign bus.large_matrix_flat[(r * MATRIX_SIZE + b * BLOCK_SIZE) * DATA_WIDTH +: ROW_BITS] = seg_q;
        end
    end

endmodule
